// File: rtl/ysyx_25060170_wb_arbiter.sv
// Writeback arbiter for the IDU register-file write port: round-robin between ALU and LSU,
// registered write port, and a per-register pending-write scoreboard that stalls issue on hazards.
module ysyx_25060170_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid_i,
    input  logic            issue_wen_i,
    input  logic [AW-1:0]   issue_rd_i,
    input  logic [AW-1:0]   issue_rs1_i,
    input  logic [AW-1:0]   issue_rs2_i,
    output logic            issue_stall_o,
    input  logic            alu_valid_i,
    input  logic [AW-1:0]   alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    output logic            alu_ready_o,
    input  logic            lsu_valid_i,
    input  logic [AW-1:0]   lsu_rd_i,
    input  logic [XLEN-1:0] lsu_data_i,
    output logic            lsu_ready_o,
    output logic            reg_write_en_o,
    output logic [AW-1:0]   reg_write_addr_o,
    output logic [XLEN-1:0] reg_write_data_o,
    output logic [NREG-1:0] busy_o
);

    // rr_ptr_q = 0 favours ALU, 1 favours LSU
    logic            rr_ptr_q, rr_ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            alu_fire, lsu_fire, wb_fire, issue_fire;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    always_comb begin
        alu_fire  = alu_valid_i & (~lsu_valid_i | ~rr_ptr_q);
        lsu_fire  = lsu_valid_i & (~alu_valid_i | rr_ptr_q);
        wb_fire   = alu_fire | lsu_fire;
        wb_rd     = lsu_fire ? lsu_rd_i : alu_rd_i;
        wb_data   = lsu_fire ? lsu_data_i : alu_data_i;
        // pointer only moves away from a source once that source has been served while favoured
        rr_ptr_d  = rr_ptr_q ^ (rr_ptr_q ? lsu_fire : alu_fire);
        wr_en_d   = wb_fire & (wb_rd != '0);
        wr_addr_d = wr_en_d ? wb_rd : wr_addr_q;
        wr_data_d = wr_en_d ? wb_data : wr_data_q;
    end

    always_comb begin
        issue_stall_o = issue_valid_i & (busy_q[issue_rs1_i] | busy_q[issue_rs2_i]
                                         | (issue_wen_i & busy_q[issue_rd_i]));
        issue_fire    = issue_valid_i & ~issue_stall_o & issue_wen_i & (issue_rd_i != '0);
    end

    // Set takes priority over clear so a re-issued rd stays pending; x0 never becomes busy.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_reg
                assign busy_d[gi] = (issue_fire & (issue_rd_i == AW'(gi)))
                                  | (busy_q[gi] & ~(wb_fire & (wb_rd == AW'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign alu_ready_o      = alu_fire;
    assign lsu_ready_o      = lsu_fire;
    assign reg_write_en_o   = wr_en_q;
    assign reg_write_addr_o = wr_addr_q;
    assign reg_write_data_o = wr_data_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_ysyx_25060170_wb_arbiter.sv
// Bench for ysyx_25060170_wb_arbiter: directed scenarios with literal expectations plus random
// traffic checked every cycle against a behavioural model of arbitration, write port and scoreboard.
module tb_ysyx_25060170_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0, issue_wen = 1'b0;
    logic [4:0]  issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0;
    logic [4:0]  alu_rd = '0, lsu_rd = '0;
    logic [31:0] alu_data = '0, lsu_data = '0;
    logic        issue_stall, alu_ready, lsu_ready, reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data, busy;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_25060170_wb_arbiter #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid), .issue_wen_i(issue_wen), .issue_rd_i(issue_rd),
        .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2), .issue_stall_o(issue_stall),
        .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
        .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
        .reg_write_en_o(reg_we), .reg_write_addr_o(reg_addr), .reg_write_data_o(reg_data),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model state: favoured source, pending set, last write
    logic [31:0] m_busy = '0, n_busy = '0;
    bit          m_fav_lsu = 0, n_fav_lsu = 0;
    bit          m_en = 0, n_en = 0;
    logic [4:0]  m_addr = '0, n_addr = '0;
    logic [31:0] m_data = '0, n_data = '0;
    bit          m_prev_fire = 0, n_prev_fire = 0;
    bit          m_alu_fire = 0, m_lsu_fire = 0;

    always @(negedge clk) begin : compare
        bit ar, lr, st, fire, ifire;
        logic [4:0]  wrd;
        logic [31:0] wd;
        if (alu_valid && lsu_valid) begin
            ar = !m_fav_lsu;
            lr = m_fav_lsu;
        end else begin
            ar = alu_valid;
            lr = lsu_valid;
        end
        st = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] || (issue_wen && m_busy[issue_rd]));
        chk("alu_ready", alu_ready, ar);
        chk("lsu_ready", lsu_ready, lr);
        chk("one_grant", alu_ready & lsu_ready, 0);
        chk("issue_stall", issue_stall, st);
        chk("wr_en", reg_we, m_en);
        chk("busy", busy, m_busy);
        if (m_en || !m_prev_fire) begin
            chk("wr_addr", reg_addr, m_addr);
            chk("wr_data", reg_data, m_data);
        end
        m_alu_fire = ar && rst;
        m_lsu_fire = lr && rst;
        fire  = m_alu_fire || m_lsu_fire;
        wrd   = m_lsu_fire ? lsu_rd : alu_rd;
        wd    = m_lsu_fire ? lsu_data : alu_data;
        ifire = rst && issue_valid && !st && issue_wen && (issue_rd != 0);
        n_busy = m_busy;
        if (fire && wrd != 0) n_busy[wrd] = 1'b0;
        if (ifire) n_busy[issue_rd] = 1'b1;
        n_fav_lsu = m_fav_lsu;
        if (m_alu_fire && !m_fav_lsu) n_fav_lsu = 1;
        if (m_lsu_fire && m_fav_lsu) n_fav_lsu = 0;
        n_en        = fire && (wrd != 0);
        n_addr      = n_en ? wrd : m_addr;
        n_data      = n_en ? wd : m_data;
        n_prev_fire = fire;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= '0; m_fav_lsu <= 0; m_en <= 0; m_addr <= '0; m_data <= '0; m_prev_fire <= 0;
        end else begin
            m_busy <= n_busy; m_fav_lsu <= n_fav_lsu; m_en <= n_en;
            m_addr <= n_addr; m_data <= n_data; m_prev_fire <= n_prev_fire;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v; alu_rd = rd; alu_data = d;
    endtask

    task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = v; lsu_rd = rd; lsu_data = d;
    endtask

    task automatic set_iss(input logic v, input logic w, input logic [4:0] rd,
                           input logic [4:0] r1, input logic [4:0] r2);
        issue_valid = v; issue_wen = w; issue_rd = rd; issue_rs1 = r1; issue_rs2 = r2;
    endtask

    bit alu_pend = 0, lsu_pend = 0;

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (alu_pend && m_alu_fire) alu_pend = 0;
            if (lsu_pend && m_lsu_fire) lsu_pend = 0;
            if (!alu_pend && $urandom_range(0, 2) != 0) begin
                alu_pend = 1; alu_rd = 5'($urandom_range(0, 9)); alu_data = $urandom;
            end
            if (!lsu_pend && $urandom_range(0, 2) != 0) begin
                lsu_pend = 1; lsu_rd = 5'($urandom_range(0, 9)); lsu_data = $urandom;
            end
            alu_valid = alu_pend;
            lsu_valid = lsu_pend;
            set_iss(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)),
                    5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
        end
    endtask

    initial begin
        // Reset held with both sources requesting
        set_alu(1, 5'd1, 32'hA1); set_lsu(1, 5'd2, 32'hB1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_en", reg_we, 0);
            chk("rst_busy", busy, 0);
        end
        tick(); rst = 1'b1; #1;
        // Contention: ALU, LSU, ALU, LSU, then ALU alone
        chk("c0_alu", alu_ready, 1); chk("c0_lsu", lsu_ready, 0);
        tick(); set_alu(1, 5'd3, 32'hA2); #1;
        chk("c1_lsu", lsu_ready, 1); chk("c1_alu", alu_ready, 0);
        chk("c1_en", reg_we, 1); chk("c1_addr", reg_addr, 1); chk("c1_data", reg_data, 32'hA1);
        tick(); set_lsu(1, 5'd4, 32'hB2); #1;
        chk("c2_alu", alu_ready, 1); chk("c2_addr", reg_addr, 2); chk("c2_data", reg_data, 32'hB1);
        tick(); set_alu(1, 5'd5, 32'hA3); #1;
        chk("c3_lsu", lsu_ready, 1); chk("c3_addr", reg_addr, 3); chk("c3_data", reg_data, 32'hA2);
        tick(); lsu_valid = 0; #1;
        chk("c4_alu", alu_ready, 1); chk("c4_addr", reg_addr, 4);
        tick(); alu_valid = 0; #1;
        chk("c5_en", reg_we, 1); chk("c5_addr", reg_addr, 5);
        tick(); #1;
        chk("c6_en", reg_we, 0);
        // Single ALU write
        tick(); set_alu(1, 5'd5, 32'hDEADBEEF); #1;
        chk("single_ready", alu_ready, 1);
        tick(); alu_valid = 0; #1;
        chk("single_en", reg_we, 1); chk("single_addr", reg_addr, 5);
        chk("single_data", reg_data, 32'hDEADBEEF);
        tick(); #1;
        chk("single_en_off", reg_we, 0);
        // x0 write from LSU
        tick(); set_lsu(1, 5'd0, 32'h12345678); #1;
        chk("x0_ready", lsu_ready, 1);
        tick(); lsu_valid = 0; #1;
        chk("x0_en", reg_we, 0); chk("x0_busy", busy, 0);
        // RAW on x7
        tick(); set_iss(1, 1, 5'd7, 5'd0, 5'd0); #1;
        chk("raw_issue_ok", issue_stall, 0);
        tick(); set_iss(1, 0, 5'd0, 5'd7, 5'd0); #1;
        chk("raw_stall", issue_stall, 1); chk("raw_busy7", busy[7], 1);
        tick(); #1;
        chk("raw_stall_hold", issue_stall, 1);
        tick(); set_alu(1, 5'd7, 32'h77); #1;
        chk("raw_stall_fire", issue_stall, 1); chk("raw_alu_ready", alu_ready, 1);
        tick(); alu_valid = 0; #1;
        chk("raw_stall_drop", issue_stall, 0); chk("raw_busy7_clr", busy[7], 0);
        chk("raw_wr_addr", reg_addr, 7);
        // Set/clear collision on x9
        tick(); set_alu(1, 5'd9, 32'h99); set_iss(1, 1, 5'd9, 5'd0, 5'd0); #1;
        chk("col_stall", issue_stall, 0); chk("col_ready", alu_ready, 1);
        tick(); alu_valid = 0; issue_valid = 0; #1;
        chk("col_busy9", busy[9], 1); chk("col_addr", reg_addr, 9);
        tick(); set_alu(1, 5'd9, 32'h999); #1;
        tick(); alu_valid = 0; #1;
        chk("col_busy9_clr", busy[9], 0);
        // Random traffic, a reset that drops an in-flight write, then more traffic
        random_cycles(1500);
        tick(); alu_pend = 1; set_alu(1, 5'd10, 32'hCAFE); lsu_pend = 0; lsu_valid = 0;
        issue_valid = 0;
        #2; rst = 1'b0; #1;
        chk("midrst_en", reg_we, 0); chk("midrst_busy", busy, 0);
        tick();
        chk("midrst_en_after_edge", reg_we, 0);
        tick(); rst = 1'b1;
        random_cycles(1000);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
